instruction_dispatch_unit: RTL and testbench

//  Upstream of the TPU control unit. Buffers 48-bit host instruction words in a small FIFO
//  and decodes them into matmul dimensions (plus dim-1 copies) and the unified-buffer start address.

---
 rtl/instruction_dispatch_unit_pkg.sv | 56 +++++
 rtl/instruction_dispatch_unit_if.sv | 35 +++
 rtl/instruction_dispatch_unit_instr_fifo.sv | 58 +++++
 rtl/instruction_dispatch_unit.sv | 179 +++++++++++++++++
 tb/tb_instruction_dispatch_unit.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instruction_dispatch_unit_pkg.sv
// Shared definitions for the instruction dispatch unit: word layout, opcodes, error codes.
package instruction_dispatch_unit_pkg;

   localparam int unsigned INSTR_W  = 48;
   localparam int unsigned OPC_W    = 4;
   localparam int unsigned DIM_W    = 7;
   localparam int unsigned ADDR_W   = 12;
   localparam int unsigned RSVD_W   = 11;

   localparam int unsigned OPC_LSB  = 44;
   localparam int unsigned V_LSB    = 37;
   localparam int unsigned U_LSB    = 30;
   localparam int unsigned ITER_LSB = 23;
   localparam int unsigned ADDR_LSB = 11;
   localparam int unsigned RSVD_LSB = 0;

   typedef enum logic [3:0] {
      OP_NOP    = 4'h0,
      OP_MATMUL = 4'h1
   } opcode_t;

   typedef enum logic [1:0] {
      ERR_NONE     = 2'b00,
      ERR_OPCODE   = 2'b01,
      ERR_ZERO_DIM = 2'b10
   } err_code_t;

   // Opcode kept as raw bits so illegal encodings survive to the decoder.
   typedef struct packed {
      logic [OPC_W-1:0]  opcode;
      logic [DIM_W-1:0]  v;
      logic [DIM_W-1:0]  u;
      logic [DIM_W-1:0]  iter;
      logic [ADDR_W-1:0] ub_addr;
      logic [RSVD_W-1:0] rsvd;
   } instr_t;

   // Builds an instruction word from its fields (host model / bench helper).
   function automatic instr_t make_instr(input logic [OPC_W-1:0]  op,
                                         input logic [DIM_W-1:0]  v,
                                         input logic [DIM_W-1:0]  u,
                                         input logic [DIM_W-1:0]  iter,
                                         input logic [ADDR_W-1:0] addr,
                                         input logic [RSVD_W-1:0] rsvd);
      logic [INSTR_W-1:0] w;
      w = '0;
      w[OPC_LSB  +: OPC_W]  = op;
      w[V_LSB    +: DIM_W]  = v;
      w[U_LSB    +: DIM_W]  = u;
      w[ITER_LSB +: DIM_W]  = iter;
      w[ADDR_LSB +: ADDR_W] = addr;
      w[RSVD_LSB +: RSVD_W] = rsvd;
      return instr_t'(w);
   endfunction

endpackage

// File: rtl/instruction_dispatch_unit_if.sv
// Host/control-unit side bundle of the instruction dispatch unit.
interface instruction_dispatch_unit_if;
   import instruction_dispatch_unit_pkg::*;

   logic              instr_valid_i;
   logic              instr_ready_o;
   instr_t            instr_data_i;
   logic              done_i;
   logic              instruction_o;
   logic [DIM_W-1:0]  V_dim_o;
   logic [DIM_W-1:0]  U_dim_o;
   logic [DIM_W-1:0]  ITER_dim_o;
   logic [DIM_W-1:0]  V_dim1_o;
   logic [DIM_W-1:0]  U_dim1_o;
   logic [DIM_W-1:0]  ITER_dim1_o;
   logic [ADDR_W-1:0] unified_buffer_start_addr_rd_o;
   logic              busy_o;
   logic              retired_o;
   logic              err_o;
   logic [1:0]        err_code_o;

   modport master (
      output instr_valid_i, instr_data_i, done_i,
      input  instr_ready_o, instruction_o,
      input  V_dim_o, U_dim_o, ITER_dim_o, V_dim1_o, U_dim1_o, ITER_dim1_o,
      input  unified_buffer_start_addr_rd_o, busy_o, retired_o, err_o, err_code_o
   );

   modport slave (
      input  instr_valid_i, instr_data_i, done_i,
      output instr_ready_o, instruction_o,
      output V_dim_o, U_dim_o, ITER_dim_o, V_dim1_o, U_dim1_o, ITER_dim1_o,
      output unified_buffer_start_addr_rd_o, busy_o, retired_o, err_o, err_code_o
   );
endinterface

// File: rtl/instruction_dispatch_unit_instr_fifo.sv
// Synchronous FIFO with registered full/empty/count; DEPTH must be a power of two >= 2.
module instruction_dispatch_unit_instr_fifo #(
   parameter int unsigned WIDTH = 48,
   parameter int unsigned DEPTH = 4,
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_c,
   output logic             full_o,
   output logic             empty_o,
   output logic [CNT_W-1:0] count_o
);
   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_nxt;
   logic             do_push;
   logic             do_pop;

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign data_c  = mem_q[rd_ptr_q];

   // Occupancy after this cycle's push/pop; drives the registered flags.
   always_comb begin
      count_nxt = count_o + CNT_W'(do_push) - CNT_W'(do_pop);
   end

   // Pointers wrap naturally at DEPTH; flags registered from the next occupancy.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_o  <= '0;
         full_o   <= 1'b0;
         empty_o  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_q + PTR_W'(do_push);
         rd_ptr_q <= rd_ptr_q + PTR_W'(do_pop);
         count_o  <= count_nxt;
         full_o   <= (count_nxt == CNT_W'(DEPTH));
         empty_o  <= (count_nxt == '0);
      end
   end

   // Storage array, no reset needed.
   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end
endmodule

// File: rtl/instruction_dispatch_unit.sv
// Buffers host instruction words, decodes matmul words and issues them one at a time.
module instruction_dispatch_unit
   import instruction_dispatch_unit_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4
) (
   input logic                        clk_i,
   input logic                        rst_i,
   instruction_dispatch_unit_if.slave bus
);
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

   typedef enum logic [1:0] {ST_IDLE, ST_DECODE, ST_ISSUE, ST_BUSY} state_t;

   state_t            state_q, state_nxt;
   instr_t            instr_q, instr_nxt;
   logic [DIM_W-1:0]  v_q, u_q, iter_q, v1_q, u1_q, iter1_q;
   logic [DIM_W-1:0]  v_nxt, u_nxt, iter_nxt, v1_nxt, u1_nxt, iter1_nxt;
   logic [ADDR_W-1:0] addr_q, addr_nxt;
   logic              issue_q, issue_nxt;
   logic              retired_q, retired_nxt;
   logic              busy_q, busy_nxt;
   logic              err_q, err_nxt;
   err_code_t         code_q, code_nxt;

   logic               fifo_push;
   logic               fifo_pop;
   logic [INSTR_W-1:0] fifo_data;
   logic               fifo_full;
   logic               fifo_empty;
   logic [CNT_W-1:0]   fifo_count;
   logic               op_legal;
   logic               dim_zero;
   logic               unused_rsvd;

   assign fifo_push   = bus.instr_valid_i && bus.instr_ready_o;
   assign unused_rsvd = ^instr_q.rsvd;

   instruction_dispatch_unit_instr_fifo #(
      .WIDTH (INSTR_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (fifo_push),
      .data_i  (bus.instr_data_i),
      .pop_i   (fifo_pop),
      .data_c  (fifo_data),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   // State register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_nxt;
      end
   end

   // Next state, FIFO pop and next values of all registered outputs.
   always_comb begin
      state_nxt   = state_q;
      fifo_pop    = 1'b0;
      instr_nxt   = instr_q;
      v_nxt       = v_q;
      u_nxt       = u_q;
      iter_nxt    = iter_q;
      v1_nxt      = v1_q;
      u1_nxt      = u1_q;
      iter1_nxt   = iter1_q;
      addr_nxt    = addr_q;
      issue_nxt   = 1'b0;
      retired_nxt = 1'b0;
      err_nxt     = err_q;
      code_nxt    = code_q;
      op_legal    = (instr_q.opcode == OP_NOP) || (instr_q.opcode == OP_MATMUL);
      dim_zero    = (instr_q.v == '0) || (instr_q.u == '0) || (instr_q.iter == '0);

      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop  = 1'b1;
               instr_nxt = instr_t'(fifo_data);
               state_nxt = ST_DECODE;
            end
         end
         ST_DECODE: begin
            state_nxt = ST_IDLE;
            if (!op_legal) begin
               if (!err_q) begin
                  err_nxt  = 1'b1;
                  code_nxt = ERR_OPCODE;
               end
            end else if (instr_q.opcode == OP_MATMUL) begin
               if (dim_zero) begin
                  if (!err_q) begin
                     err_nxt  = 1'b1;
                     code_nxt = ERR_ZERO_DIM;
                  end
               end else begin
                  v_nxt     = instr_q.v;
                  u_nxt     = instr_q.u;
                  iter_nxt  = instr_q.iter;
                  v1_nxt    = instr_q.v - 7'd1;
                  u1_nxt    = instr_q.u - 7'd1;
                  iter1_nxt = instr_q.iter - 7'd1;
                  addr_nxt  = instr_q.ub_addr;
                  issue_nxt = 1'b1;
                  state_nxt = ST_ISSUE;
               end
            end
         end
         ST_ISSUE: begin
            state_nxt = ST_BUSY;
         end
         ST_BUSY: begin
            if (bus.done_i) begin
               retired_nxt = 1'b1;
               state_nxt   = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase

      busy_nxt = (state_nxt != ST_IDLE) || fifo_push || (fifo_count > CNT_W'(fifo_pop));
   end

   // Output and decode registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         instr_q   <= '0;
         v_q       <= '0;
         u_q       <= '0;
         iter_q    <= '0;
         v1_q      <= '0;
         u1_q      <= '0;
         iter1_q   <= '0;
         addr_q    <= '0;
         issue_q   <= 1'b0;
         retired_q <= 1'b0;
         busy_q    <= 1'b0;
         err_q     <= 1'b0;
         code_q    <= ERR_NONE;
      end else begin
         instr_q   <= instr_nxt;
         v_q       <= v_nxt;
         u_q       <= u_nxt;
         iter_q    <= iter_nxt;
         v1_q      <= v1_nxt;
         u1_q      <= u1_nxt;
         iter1_q   <= iter1_nxt;
         addr_q    <= addr_nxt;
         issue_q   <= issue_nxt;
         retired_q <= retired_nxt;
         busy_q    <= busy_nxt;
         err_q     <= err_nxt;
         code_q    <= code_nxt;
      end
   end

   assign bus.instr_ready_o                  = ~fifo_full;
   assign bus.instruction_o                  = issue_q;
   assign bus.V_dim_o                        = v_q;
   assign bus.U_dim_o                        = u_q;
   assign bus.ITER_dim_o                     = iter_q;
   assign bus.V_dim1_o                       = v1_q;
   assign bus.U_dim1_o                       = u1_q;
   assign bus.ITER_dim1_o                    = iter1_q;
   assign bus.unified_buffer_start_addr_rd_o = addr_q;
   assign bus.busy_o                         = busy_q;
   assign bus.retired_o                      = retired_q;
   assign bus.err_o                          = err_q;
   assign bus.err_code_o                     = code_q;
endmodule

// File: tb/tb_instruction_dispatch_unit.sv
// Bench for instruction_dispatch_unit: directed latency sequences, a decode vector table and a streaming scoreboard.
module tb_instruction_dispatch_unit;
   import instruction_dispatch_unit_pkg::*;

   localparam logic [3:0] MM  = 4'h1;
   localparam logic [3:0] NOP = 4'h0;
   localparam logic [3:0] BAD = 4'hF;

   typedef struct packed {
      logic [6:0]  v, u, i, v1, u1, i1;
      logic [11:0] a;
   } exp_t;

   typedef struct {
      logic        rst_before;
      instr_t      word;
      logic        exp_pulse;
      logic [6:0]  ev, eu, ei;
      logic [11:0] ea;
      logic        eerr;
      logic [1:0]  ecode;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_pass = 0;
   int   pulse_cnt = 0;
   int   retired_cnt = 0;
   exp_t sb_q[$];
   exp_t mon_e;
   vec_t vecs[10];

   instruction_dispatch_unit_if bus();

   instruction_dispatch_unit #(.FIFO_DEPTH(4)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic issuable(input instr_t w);
      return (w.opcode == MM) && (w.v != 0) && (w.u != 0) && (w.iter != 0);
   endfunction

   function automatic exp_t expect_of(input instr_t w);
      exp_t e;
      e.v = w.v; e.u = w.u; e.i = w.iter;
      e.v1 = 7'(w.v - 7'd1); e.u1 = 7'(w.u - 7'd1); e.i1 = 7'(w.iter - 7'd1);
      e.a = w.ub_addr;
      return e;
   endfunction

   task automatic do_reset();
      bus.instr_valid_i = 1'b0;
      bus.done_i = 1'b0;
      rst = 1'b1;
      step();
      step();
      sb_q.delete();
      rst = 1'b0;
      step();
   endtask

   // Returns just after the accepting edge.
   task automatic push_word(input instr_t w);
      int n;
      n = 0;
      bus.instr_valid_i = 1'b1;
      bus.instr_data_i = w;
      while (!bus.instr_ready_o && n < 100) begin
         step();
         n++;
      end
      if (n >= 100) check("push_timeout", bus.instr_ready_o, 1);
      if (issuable(w)) sb_q.push_back(expect_of(w));
      step();
      bus.instr_valid_i = 1'b0;
   endtask

   // Answers every issue with done one cycle into BUSY until the unit goes idle.
   task automatic drain(input int max_cycles);
      int n;
      n = 0;
      while (bus.busy_o && n < max_cycles) begin
         if (bus.instruction_o) begin
            step();
            bus.done_i = 1'b1;
            step();
            bus.done_i = 1'b0;
         end else begin
            step();
         end
         n++;
      end
      if (bus.busy_o) check("drain_timeout", bus.busy_o, 0);
   endtask

   // Scoreboard: every issue pulse must match the oldest expected matmul.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.instruction_o) begin
            pulse_cnt++;
            if (sb_q.size() == 0) begin
               check("sb_underflow", bus.instruction_o, 0);
            end else begin
               mon_e = sb_q.pop_front();
               check("issue_fields", {bus.V_dim_o, bus.U_dim_o, bus.ITER_dim_o, bus.V_dim1_o,
                     bus.U_dim1_o, bus.ITER_dim1_o, bus.unified_buffer_start_addr_rd_o}, mon_e);
            end
         end
         if (bus.retired_o) retired_cnt++;
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int p0, r0, acc, idx, n;
      logic rdy, prev_issue;
      instr_t w5[5];
      instr_t ws[10];

      vecs[0] = '{1'b1, make_instr(MM, 7'd5, 7'd0, 7'd3, 12'h123, 11'h0),    1'b0, 7'd0,  7'd0,  7'd0,  12'h000, 1'b1, 2'b10};
      vecs[1] = '{1'b0, make_instr(BAD, 7'd7, 7'd7, 7'd7, 12'h007, 11'h0),   1'b0, 7'd0,  7'd0,  7'd0,  12'h000, 1'b1, 2'b10};
      vecs[2] = '{1'b0, make_instr(MM, 7'd64, 7'd64, 7'd64, 12'hFFF, 11'h5A5), 1'b1, 7'd64, 7'd64, 7'd64, 12'hFFF, 1'b1, 2'b10};
      vecs[3] = '{1'b0, make_instr(NOP, 7'd3, 7'd3, 7'd3, 12'h333, 11'h0),   1'b0, 7'd64, 7'd64, 7'd64, 12'hFFF, 1'b1, 2'b10};
      vecs[4] = '{1'b0, make_instr(MM, 7'd127, 7'd1, 7'd0, 12'h044, 11'h0),  1'b0, 7'd64, 7'd64, 7'd64, 12'hFFF, 1'b1, 2'b10};
      vecs[5] = '{1'b1, make_instr(NOP, 7'd1, 7'd2, 7'd3, 12'h004, 11'h0),   1'b0, 7'd0,  7'd0,  7'd0,  12'h000, 1'b0, 2'b00};
      vecs[6] = '{1'b0, make_instr(MM, 7'd2, 7'd2, 7'd2, 12'h002, 11'h7FF),  1'b1, 7'd2,  7'd2,  7'd2,  12'h002, 1'b0, 2'b00};
      vecs[7] = '{1'b0, make_instr(BAD, 7'd9, 7'd9, 7'd9, 12'h999, 11'h0),   1'b0, 7'd2,  7'd2,  7'd2,  12'h002, 1'b1, 2'b01};
      vecs[8] = '{1'b0, make_instr(MM, 7'd1, 7'd1, 7'd1, 12'h001, 11'h0),    1'b1, 7'd1,  7'd1,  7'd1,  12'h001, 1'b1, 2'b01};
      vecs[9] = '{1'b0, make_instr(MM, 7'd0, 7'd5, 7'd5, 12'h055, 11'h0),    1'b0, 7'd1,  7'd1,  7'd1,  12'h001, 1'b1, 2'b01};

      bus.instr_valid_i = 1'b0;
      bus.instr_data_i = '0;
      bus.done_i = 1'b0;
      step();
      step();

      // Reset values.
      check("rst_ready", bus.instr_ready_o, 1);
      check("rst_busy", bus.busy_o, 0);
      check("rst_instruction", bus.instruction_o, 0);
      check("rst_retired", bus.retired_o, 0);
      check("rst_err", {bus.err_o, bus.err_code_o}, 0);
      check("rst_dims", {bus.V_dim_o, bus.U_dim_o, bus.ITER_dim_o, bus.V_dim1_o, bus.U_dim1_o,
            bus.ITER_dim1_o, bus.unified_buffer_start_addr_rd_o}, 0);
      rst = 1'b0;
      step();

      // Reset while a matmul is in flight.
      push_word(make_instr(MM, 7'd3, 7'd3, 7'd3, 12'h005, 11'h0));
      step();
      step();
      step();
      check("pre_reset_busy", bus.busy_o, 1);
      rst = 1'b1;
      #1;
      check("midreset_busy", bus.busy_o, 0);
      check("midreset_ready", bus.instr_ready_o, 1);
      check("midreset_dims", {bus.V_dim_o, bus.unified_buffer_start_addr_rd_o}, 0);
      step();
      sb_q.delete();
      rst = 1'b0;
      step();

      // Issue latency for MATMUL 8/4/2 @ 0x010.
      push_word(make_instr(MM, 7'd8, 7'd4, 7'd2, 12'h010, 11'h7FF));
      check("k_busy", bus.busy_o, 1);
      check("k_instruction", bus.instruction_o, 0);
      step();
      check("k1_instruction", bus.instruction_o, 0);
      step();
      check("k2_instruction", bus.instruction_o, 1);
      check("k2_dims", {bus.V_dim_o, bus.U_dim_o, bus.ITER_dim_o}, {7'd8, 7'd4, 7'd2});
      check("k2_dim1", {bus.V_dim1_o, bus.U_dim1_o, bus.ITER_dim1_o}, {7'd7, 7'd3, 7'd1});
      check("k2_addr", bus.unified_buffer_start_addr_rd_o, 12'h010);
      step();
      check("k3_instruction", bus.instruction_o, 0);
      step();
      step();
      check("k5_busy_wait", bus.busy_o, 1);
      bus.done_i = 1'b1;
      step();
      bus.done_i = 1'b0;
      check("done_retired", bus.retired_o, 1);
      check("done_busy", bus.busy_o, 0);
      step();
      check("retired_one_cycle", bus.retired_o, 0);

      // done_i outside BUSY is ignored.
      r0 = retired_cnt;
      bus.done_i = 1'b1;
      step();
      step();
      bus.done_i = 1'b0;
      check("done_idle_ignored", retired_cnt - r0, 0);
      push_word(make_instr(MM, 7'd2, 7'd3, 7'd4, 12'h020, 11'h0));
      step();
      step();
      check("issue_cycle", bus.instruction_o, 1);
      bus.done_i = 1'b1;
      step();
      bus.done_i = 1'b0;
      check("done_issue_no_retire", bus.retired_o, 0);
      step();
      check("done_issue_still_busy", {bus.busy_o, bus.retired_o}, 2'b10);
      bus.done_i = 1'b1;
      step();
      bus.done_i = 1'b0;
      check("done_busy_retire", bus.retired_o, 1);
      step();
      check("retire_once", retired_cnt - r0, 1);

      // done_i in the first BUSY cycle counts.
      push_word(make_instr(MM, 7'd6, 7'd6, 7'd6, 12'h066, 11'h0));
      step();
      step();
      step();
      bus.done_i = 1'b1;
      step();
      bus.done_i = 1'b0;
      check("done_on_busy_entry", bus.retired_o, 1);
      step();

      // FIFO fills while the unit is stalled in BUSY.
      push_word(make_instr(MM, 7'd1, 7'd1, 7'd1, 12'h001, 11'h0));
      step();
      step();
      step();
      p0 = pulse_cnt;
      for (int i = 0; i < 5; i++)
         w5[i] = make_instr(MM, 7'(10 + i), 7'(20 + i), 7'(30 + i), 12'(12'h100 + i), 11'h0);
      acc = 0;
      n = 0;
      bus.instr_valid_i = 1'b1;
      bus.instr_data_i = w5[0];
      while (acc < 4 && n < 20) begin
         rdy = bus.instr_ready_o;
         if (rdy) sb_q.push_back(expect_of(w5[acc]));
         step();
         if (rdy) begin
            acc++;
            bus.instr_data_i = w5[acc];
         end
         n++;
      end
      check("stall_accepted", acc, 4);
      check("stall_full_ready", bus.instr_ready_o, 0);
      step();
      step();
      step();
      check("stall_hold_ready", bus.instr_ready_o, 0);
      bus.done_i = 1'b1;
      step();
      bus.done_i = 1'b0;
      check("full_pop_no_bypass", {bus.instr_ready_o, bus.retired_o}, 2'b01);
      step();
      check("ready_after_pop", {bus.instr_ready_o, bus.instruction_o}, 2'b10);
      sb_q.push_back(expect_of(w5[4]));
      step();
      bus.instr_valid_i = 1'b0;
      check("b2b_issue_gap", bus.instruction_o, 1);
      drain(300);
      check("stall_pulses", pulse_cnt - p0, 5);
      check("stall_sb_empty", sb_q.size(), 0);

      // Decode table: errors, NOPs and output hold behaviour.
      for (int i = 0; i < 10; i++) begin
         if (vecs[i].rst_before) do_reset();
         p0 = pulse_cnt;
         push_word(vecs[i].word);
         drain(60);
         check($sformatf("vec%0d_pulses", i), pulse_cnt - p0, vecs[i].exp_pulse);
         check($sformatf("vec%0d_dims", i), {bus.V_dim_o, bus.U_dim_o, bus.ITER_dim_o},
               {vecs[i].ev, vecs[i].eu, vecs[i].ei});
         check($sformatf("vec%0d_dim1", i), {bus.V_dim1_o, bus.U_dim1_o, bus.ITER_dim1_o},
               {(vecs[i].ev == 0) ? 7'd0 : 7'(vecs[i].ev - 7'd1),
                (vecs[i].eu == 0) ? 7'd0 : 7'(vecs[i].eu - 7'd1),
                (vecs[i].ei == 0) ? 7'd0 : 7'(vecs[i].ei - 7'd1)});
         check($sformatf("vec%0d_addr", i), bus.unified_buffer_start_addr_rd_o, vecs[i].ea);
         check($sformatf("vec%0d_err", i), {bus.err_o, bus.err_code_o}, {vecs[i].eerr, vecs[i].ecode});
      end

      // Streaming ten matmuls through the FIFO so both pointers wrap.
      ws[0] = make_instr(MM, 7'd64, 7'd64, 7'd64, 12'hFFF, 11'h0);
      for (int i = 1; i < 10; i++)
         ws[i] = make_instr(MM, 7'($urandom_range(127, 1)), 7'($urandom_range(127, 1)),
                            7'($urandom_range(127, 1)), 12'($urandom), 11'($urandom));
      p0 = pulse_cnt;
      r0 = retired_cnt;
      idx = 0;
      n = 0;
      prev_issue = 1'b0;
      bus.instr_valid_i = 1'b1;
      bus.instr_data_i = ws[0];
      while ((idx < 10 || bus.busy_o) && n < 500) begin
         bus.done_i = prev_issue;
         prev_issue = bus.instruction_o;
         rdy = bus.instr_valid_i && bus.instr_ready_o;
         if (rdy) sb_q.push_back(expect_of(ws[idx]));
         step();
         if (rdy) begin
            idx++;
            if (idx < 10) bus.instr_data_i = ws[idx];
            else bus.instr_valid_i = 1'b0;
         end
         n++;
      end
      bus.done_i = 1'b0;
      bus.instr_valid_i = 1'b0;
      if (n >= 500) check("stream_timeout", bus.busy_o, 0);
      step();
      check("stream_pulses", pulse_cnt - p0, 10);
      check("stream_retired", retired_cnt - r0, 10);
      check("stream_sb_empty", sb_q.size(), 0);
      check("err_sticky_end", {bus.err_o, bus.err_code_o}, 3'b101);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
